symbol_bit_packer: RTL

SYMBOL_BIT_PACKER -- requirements
Module: symbol_bit_packer

---
 rtl/symbol_bit_packer.sv | 99 +++++++++
 1 files changed

// File: rtl/symbol_bit_packer.sv
// Packs 1..4-bit demodulated symbols MSB-first into bytes, with a single output
// slot held under backpressure and a flush that emits a zero-padded final byte.
module symbol_bit_packer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sym_valid,
    output logic       sym_ready,
    input  logic [1:0] sel,
    input  logic [3:0] bit_in,
    input  logic       flush,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       byte_last
);

    // Bits are kept right-aligned; the oldest bit sits at position cnt-1.
    // Bits above cnt are stale and never reach an output.
    logic [10:0] acc;
    logic [3:0]  cnt;
    logic        flush_pending;

    logic        accept;
    logic        slot_free;
    logic        pend;
    logic [2:0]  n;
    logic [3:0]  sym_bits;
    logic [14:0] nxt_acc;
    logic [4:0]  nxt_cnt;
    logic [14:0] full_sh;
    logic [14:0] pad_sh;
    logic        emit_full;
    logic        emit_pad;

    assign sym_ready = (cnt < 4'd8) || byte_ready;
    assign accept    = sym_valid && sym_ready;
    assign slot_free = !byte_valid || byte_ready;
    assign pend      = flush_pending || flush;
    assign n         = {1'b0, sel} + 3'd1;

    always_comb begin
        sym_bits = 4'h0;
        case (sel)
            2'b00: sym_bits = {3'b000, bit_in[0]};
            2'b01: sym_bits = {2'b00, bit_in[1:0]};
            2'b10: sym_bits = {1'b0, bit_in[2:0]};
            default: sym_bits = bit_in;
        endcase
    end

    always_comb begin
        nxt_acc = {4'h0, acc};
        nxt_cnt = {1'b0, cnt};
        if (accept) begin
            nxt_acc = ({4'h0, acc} << n) | {11'h0, sym_bits};
            nxt_cnt = {1'b0, cnt} + {2'b00, n};
        end
    end

    assign full_sh   = nxt_acc >> (nxt_cnt - 5'd8);
    assign pad_sh    = nxt_acc << (5'd8 - nxt_cnt);
    assign emit_full = slot_free && (nxt_cnt >= 5'd8);
    assign emit_pad  = slot_free && pend && (nxt_cnt != 5'd0) && (nxt_cnt < 5'd8);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc           <= '0;
            cnt           <= '0;
            flush_pending <= 1'b0;
            byte_out      <= 8'h00;
            byte_valid    <= 1'b0;
            byte_last     <= 1'b0;
        end else begin
            acc <= nxt_acc[10:0];
            if (emit_full) begin
                byte_out      <= full_sh[7:0];
                byte_valid    <= 1'b1;
                byte_last     <= 1'b0;
                cnt           <= 4'(nxt_cnt - 5'd8);
                flush_pending <= pend;
            end else if (emit_pad) begin
                byte_out      <= pad_sh[7:0];
                byte_valid    <= 1'b1;
                byte_last     <= 1'b1;
                cnt           <= 4'd0;
                flush_pending <= 1'b0;
            end else begin
                cnt <= nxt_cnt[3:0];
                // An empty accumulator has nothing to flush, so the request just retires.
                flush_pending <= pend && (nxt_cnt != 5'd0);
                if (byte_ready) begin
                    byte_valid <= 1'b0;
                    byte_last  <= 1'b0;
                end
            end
        end
    end

endmodule
